// File: rtl/silife_ws2812_pkg.sv
// Shared definitions for the SiLife WS2812 driver: FSM encoding, GRB bit order
// and default WS2812 timing for common system clocks.
package silife_ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int unsigned COLOR_W   = 24;
  localparam int unsigned BIT_CNT_W = 5;
  localparam logic [BIT_CNT_W-1:0] FIRST_BIT = 5'd23;

  // 25 MHz clock: 40 ns per cycle
  localparam int unsigned BIT_CYCLES_25M   = 31;
  localparam int unsigned T0H_CYCLES_25M   = 10;
  localparam int unsigned T1H_CYCLES_25M   = 20;
  localparam int unsigned RESET_CYCLES_25M = 2000;

  // 10 MHz clock: 100 ns per cycle
  localparam int unsigned BIT_CYCLES_10M   = 13;
  localparam int unsigned T0H_CYCLES_10M   = 4;
  localparam int unsigned T1H_CYCLES_10M   = 8;
  localparam int unsigned RESET_CYCLES_10M = 500;

  // Wire order is G7..G0, R7..R0, B7..B0; bit 23 goes out first.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  function automatic logic grb_bit(input grb_t color, input logic [BIT_CNT_W-1:0] idx);
    return color[idx];
  endfunction

endpackage

// File: rtl/silife_ws2812_bit.sv
// Single WS2812 bit encoder: one NRZ slot per i_start, o_done on its last cycle.
module silife_ws2812_bit #(
  parameter int unsigned BIT_CYCLES = 31,
  parameter int unsigned T0H_CYCLES = 10,
  parameter int unsigned T1H_CYCLES = 20,
  parameter int unsigned PHASE_W    = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_bit,
  output logic o_data,
  output logic o_done
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BIT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] T0H_P      = PHASE_W'(T0H_CYCLES);
  localparam logic [PHASE_W-1:0] T1H_P      = PHASE_W'(T1H_CYCLES);

  logic               active;
  logic               bit_val;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_inc;
  logic [PHASE_W-1:0] high_len;

  assign phase_inc = phase + 1'b1;
  assign high_len  = bit_val ? T1H_P : T0H_P;

  // A start on the done cycle chains slots with no gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      bit_val <= 1'b0;
      phase   <= '0;
      o_data  <= 1'b0;
      o_done  <= 1'b0;
    end else if (i_start) begin
      active  <= 1'b1;
      bit_val <= i_bit;
      phase   <= '0;
      o_data  <= 1'b1;
      o_done  <= (LAST_PHASE == '0);
    end else if (active) begin
      if (phase == LAST_PHASE) begin
        active <= 1'b0;
        phase  <= '0;
        o_data <= 1'b0;
        o_done <= 1'b0;
      end else begin
        phase  <= phase_inc;
        o_data <= (phase_inc < high_len);
        o_done <= (phase_inc == LAST_PHASE);
      end
    end
  end

endmodule

// File: rtl/silife_ws2812.sv
// WS2812 driver for the SiLife matrix: scans rows, sends each cell as a GRB
// colour, then holds the line low to latch the strip.
module silife_ws2812
  import silife_ws2812_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned HEIGHT       = 8,
  parameter int unsigned BIT_CYCLES   = 31,
  parameter int unsigned T0H_CYCLES   = 10,
  parameter int unsigned T1H_CYCLES   = 20,
  parameter int unsigned RESET_CYCLES = 2000,
  parameter logic [23:0] ON_COLOR     = 24'h101010,
  parameter logic [23:0] OFF_COLOR    = 24'h000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  input  logic [WIDTH-1:0]          i_cells,
  output logic [$clog2(HEIGHT)-1:0] o_row_select,
  output logic                      o_data,
  output logic                      o_busy
);

  localparam int unsigned ROW_W   = $clog2(HEIGHT);
  localparam int unsigned PIX_W   = $clog2(WIDTH);
  localparam int unsigned MAX_CYC = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int unsigned PHASE_W = $clog2(MAX_CYC + 1);

  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(HEIGHT - 1);
  localparam logic [PIX_W-1:0]   LAST_PIX   = PIX_W'(WIDTH - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(RESET_CYCLES - 1);

  state_t                 state;
  logic [PIX_W-1:0]       pixel;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]       row_buf;
  logic [WIDTH-1:0]       row_next;
  logic [PHASE_W-1:0]     latch_cnt;
  logic                   bit_start;
  logic                   bit_value;
  logic                   bit_done;

  function automatic grb_t cell_color(input logic alive);
    return alive ? grb_t'(ON_COLOR) : grb_t'(OFF_COLOR);
  endfunction

  // Leftmost pixel always sits at the top of the row shift register.
  assign row_next = row_buf << 1;

  // Next bit is launched on the done cycle so slots chain back-to-back.
  always_comb begin
    bit_start = 1'b0;
    bit_value = 1'b0;
    case (state)
      FETCH: begin
        bit_start = 1'b1;
        bit_value = grb_bit(cell_color(i_cells[WIDTH-1]), FIRST_BIT);
      end
      SEND: begin
        if (bit_done) begin
          if (bit_cnt != '0) begin
            bit_start = 1'b1;
            bit_value = grb_bit(cell_color(row_buf[WIDTH-1]), bit_cnt - 5'd1);
          end else if (pixel != LAST_PIX) begin
            bit_start = 1'b1;
            bit_value = grb_bit(cell_color(row_next[WIDTH-1]), FIRST_BIT);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      o_row_select <= '0;
      o_busy       <= 1'b0;
      pixel        <= '0;
      bit_cnt      <= '0;
      row_buf      <= '0;
      latch_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable) begin
            state        <= FETCH;
            o_row_select <= '0;
            o_busy       <= 1'b1;
          end
        end
        FETCH: begin
          row_buf <= i_cells;
          pixel   <= '0;
          bit_cnt <= FIRST_BIT;
          state   <= SEND;
        end
        SEND: begin
          if (bit_done) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 5'd1;
            end else if (pixel != LAST_PIX) begin
              pixel   <= pixel + 1'b1;
              bit_cnt <= FIRST_BIT;
              row_buf <= row_next;
            end else begin
              pixel <= '0;
              if (o_row_select != LAST_ROW) begin
                o_row_select <= o_row_select + 1'b1;
                state        <= FETCH;
              end else begin
                latch_cnt <= '0;
                state     <= LATCH;
              end
            end
          end
        end
        LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            latch_cnt    <= '0;
            o_row_select <= '0;
            if (i_enable) begin
              state <= FETCH;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  silife_ws2812_bit #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .PHASE_W    (PHASE_W)
  ) u_bit (
    .clk     (clk),
    .reset   (reset),
    .i_start (bit_start),
    .i_bit   (bit_value),
    .o_data  (o_data),
    .o_done  (bit_done)
  );

endmodule
